muldiv_issue: RTL and testbench

Pipeline-side initiator for the iterative RV32M multiply/divide unit. It accepts one decoded M-extension instruction from the execute stage and drives the unit's req/resp/kill interface. It tracks the single outstanding operation, handles flush and timeout, and presents the result to register-file writeback.

---
 rtl/muldiv_issue.sv | 149 ++++++++++++++
 tb/tb_muldiv_issue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issue.sv
// Issue-side controller for the iterative RV32M multiply/divide unit.
// Holds one M-extension operation from accept through request, wait and writeback.
module muldiv_issue #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [2:0]       inst_funct3,
    input  logic [XLEN-1:0]  inst_rs1,
    input  logic [XLEN-1:0]  inst_rs2,
    input  logic [TAG_W-1:0] inst_rd,
    input  logic             flush,
    output logic             md_req_valid,
    input  logic             md_req_ready,
    output logic [3:0]       md_req_fn,
    output logic             md_req_dw,
    output logic [XLEN-1:0]  md_req_in1,
    output logic [XLEN-1:0]  md_req_in2,
    output logic [TAG_W-1:0] md_req_tag,
    output logic             md_kill,
    input  logic             md_resp_valid,
    output logic             md_resp_ready,
    input  logic [XLEN-1:0]  md_resp_data,
    input  logic [TAG_W-1:0] md_resp_tag,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             timeout_err,
    output logic             tag_err,
    output logic [31:0]      done_count
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t             r_state;
    logic [3:0]         r_fn;
    logic [XLEN-1:0]    r_in1;
    logic [XLEN-1:0]    r_in2;
    logic [TAG_W-1:0]   r_rd;
    logic [XLEN-1:0]    r_wb_data;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [31:0]        r_done_count;

    logic w_idle;
    logic w_req;
    logic w_wait;
    logic w_wb;
    logic w_resp_fire;
    logic w_timeout_kill;

    assign w_idle = (r_state == S_IDLE);
    assign w_req  = (r_state == S_REQ);
    assign w_wait = (r_state == S_WAIT);
    assign w_wb   = (r_state == S_WB);

    // A response arriving on the last allowed cycle beats the timeout.
    assign w_resp_fire    = w_wait && !flush && md_resp_valid;
    assign w_timeout_kill = w_wait && !flush && !md_resp_valid && (r_wait_cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fn         <= '0;
            r_in1        <= '0;
            r_in2        <= '0;
            r_rd         <= '0;
            r_wb_data    <= '0;
            r_wait_cnt   <= '0;
            r_done_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inst_valid && !flush) begin
                        r_fn    <= {1'b0, inst_funct3};
                        r_in1   <= inst_rs1;
                        r_in2   <= inst_rs2;
                        r_rd    <= inst_rd;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (md_req_ready) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (md_resp_valid) begin
                        r_wb_data <= md_resp_data;
                        r_state   <= S_WB;
                    end else if (r_wait_cnt == CNT_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WB: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (wb_ready) begin
                        r_done_count <= r_done_count + 32'd1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign inst_ready    = w_idle;
    assign md_req_valid  = w_req && !flush;
    assign md_resp_ready = w_wait && !flush;
    assign wb_valid      = w_wb && !flush;

    // Request fields read as zero while idle so nothing stale leaks onto the bus.
    assign md_req_fn  = w_idle ? 4'd0 : r_fn;
    assign md_req_dw  = !w_idle;
    assign md_req_in1 = w_idle ? '0 : r_in1;
    assign md_req_in2 = w_idle ? '0 : r_in2;
    assign md_req_tag = w_idle ? '0 : r_rd;

    assign md_kill     = w_wait && (flush || w_timeout_kill);
    assign timeout_err = w_timeout_kill;
    assign tag_err     = w_resp_fire && (md_resp_tag != r_rd);

    // Writeback always targets the issued rd, even if the unit returned a different tag.
    assign wb_rd      = w_wb ? r_rd : '0;
    assign wb_data    = w_wb ? r_wb_data : '0;
    assign done_count = r_done_count;

endmodule

// File: tb/tb_muldiv_issue.sv
// Directed bench for muldiv_issue: the bench plays execute stage, mul/div unit and writeback port,
// and a per-cycle compare process checks every output against the bench's own expectations.
module tb_muldiv_issue;

    localparam int TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  inst_funct3;
    logic [31:0] inst_rs1;
    logic [31:0] inst_rs2;
    logic [4:0]  inst_rd;
    logic        flush;
    logic        md_req_valid;
    logic        md_req_ready;
    logic [3:0]  md_req_fn;
    logic        md_req_dw;
    logic [31:0] md_req_in1;
    logic [31:0] md_req_in2;
    logic [4:0]  md_req_tag;
    logic        md_kill;
    logic        md_resp_valid;
    logic        md_resp_ready;
    logic [31:0] md_resp_data;
    logic [4:0]  md_resp_tag;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;
    logic        tag_err;
    logic [31:0] done_count;

    always #5 clock = ~clock;

    muldiv_issue #(.XLEN(32), .TAG_W(5), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_funct3(inst_funct3),
        .inst_rs1(inst_rs1), .inst_rs2(inst_rs2), .inst_rd(inst_rd), .flush(flush),
        .md_req_valid(md_req_valid), .md_req_ready(md_req_ready), .md_req_fn(md_req_fn),
        .md_req_dw(md_req_dw), .md_req_in1(md_req_in1), .md_req_in2(md_req_in2),
        .md_req_tag(md_req_tag), .md_kill(md_kill), .md_resp_valid(md_resp_valid),
        .md_resp_ready(md_resp_ready), .md_resp_data(md_resp_data), .md_resp_tag(md_resp_tag),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .timeout_err(timeout_err), .tag_err(tag_err), .done_count(done_count)
    );

    int total = 0;
    int bad   = 0;

    // Bench-side view of the operation: phase 0 idle, 1 requesting, 2 waiting, 3 writeback.
    int          ph = 0;
    bit          chk_en = 1'b0;
    logic [2:0]  exp_f3 = '0;
    logic [31:0] exp_in1 = '0;
    logic [31:0] exp_in2 = '0;
    logic [4:0]  exp_rd = '0;
    logic [31:0] exp_wb = '0;
    logic [31:0] exp_done = '0;
    logic        exp_kill = 1'b0;
    logic        exp_to = 1'b0;
    logic        exp_tagerr = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // RV32M reference arithmetic, including the divide-by-zero and overflow rules.
    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        case (f3)
            3'd0: return a * b;
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ua); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = 64'(sa / sb);
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb);
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("inst_ready", inst_ready, ph == 0);
            chk("md_req_valid", md_req_valid, ph == 1 && !flush);
            chk("md_resp_ready", md_resp_ready, ph == 2 && !flush);
            chk("wb_valid", wb_valid, ph == 3 && !flush);
            chk("md_kill", md_kill, exp_kill);
            chk("timeout_err", timeout_err, exp_to);
            chk("tag_err", tag_err, exp_tagerr);
            chk("done_count", done_count, exp_done);
            if (ph == 0) begin
                chk("idle_req_fields", {md_req_fn, md_req_dw, md_req_in1, md_req_in2, md_req_tag}, '0);
            end else begin
                chk("md_req_fn", md_req_fn, {1'b0, exp_f3});
                chk("md_req_dw", md_req_dw, 1'b1);
                chk("md_req_in1", md_req_in1, exp_in1);
                chk("md_req_in2", md_req_in2, exp_in2);
                chk("md_req_tag", md_req_tag, exp_rd);
            end
            if (ph == 3) begin
                chk("wb_rd", wb_rd, exp_rd);
                chk("wb_data", wb_data, exp_wb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=no_finish want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_to_wait(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input int stall);
        inst_valid  = 1'b1;
        inst_funct3 = f3;
        inst_rs1    = a;
        inst_rs2    = b;
        inst_rd     = rd;
        exp_f3 = f3; exp_in1 = a; exp_in2 = b; exp_rd = rd;
        step();
        inst_valid  = 1'b0;
        inst_rs1    = $urandom;
        inst_rs2    = $urandom;
        inst_rd     = 5'($urandom);
        inst_funct3 = 3'($urandom);
        ph = 1;
        repeat (stall) step();
        md_req_ready = 1'b1;
        step();
        md_req_ready = 1'b0;
        ph = 2;
    endtask

    task automatic respond(input int lat, input logic [4:0] rtag);
        repeat (lat - 1) step();
        exp_wb        = model_res(exp_f3, exp_in1, exp_in2);
        md_resp_valid = 1'b1;
        md_resp_data  = exp_wb;
        md_resp_tag   = rtag;
        exp_tagerr    = (rtag != exp_rd);
        step();
        md_resp_valid = 1'b0;
        md_resp_data  = $urandom;
        exp_tagerr    = 1'b0;
        ph = 3;
    endtask

    task automatic finish_wb(input int hold, input logic [4:0] lit_rd, input logic [31:0] lit_data);
        repeat (hold) step();
        wb_ready = 1'b1;
        @(negedge clock);
        chk("lit_wb_rd", wb_rd, lit_rd);
        chk("lit_wb_data", wb_data, lit_data);
        @(posedge clock);
        #1;
        wb_ready = 1'b0;
        ph = 0;
        exp_done = exp_done + 32'd1;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int stall, input int lat,
                          input logic [4:0] rtag, input int hold, input logic [31:0] lit);
        issue_to_wait(f3, a, b, rd, stall);
        respond(lat, rtag);
        finish_wb(hold, rd, lit);
    endtask

    task automatic flush_in_wait(input int cyc, input logic with_resp);
        issue_to_wait(3'd0, 32'd11, 32'd13, 5'd12, 0);
        repeat (cyc - 1) step();
        flush         = 1'b1;
        exp_kill      = 1'b1;
        md_resp_valid = with_resp;
        md_resp_data  = 32'hDEAD_BEEF;
        md_resp_tag   = 5'd12;
        step();
        flush         = 1'b0;
        md_resp_valid = 1'b0;
        exp_kill      = 1'b0;
        ph = 0;
    endtask

    initial begin
        reset = 1'b1; inst_valid = 1'b0; inst_funct3 = '0; inst_rs1 = '0; inst_rs2 = '0;
        inst_rd = '0; flush = 1'b0; md_req_ready = 1'b0; md_resp_valid = 1'b0;
        md_resp_data = '0; md_resp_tag = '0; wb_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        ph = 0;
        exp_done = '0;
        chk_en = 1'b1;
        @(negedge clock);
        chk("reset_inst_ready", inst_ready, 1'b1);
        chk("reset_outputs", {md_req_valid, md_kill, md_resp_ready, wb_valid, wb_rd, wb_data,
                              timeout_err, tag_err, done_count}, '0);
        step();

        run_op(3'd0, 32'd3, 32'd5, 5'd7, 0, 33, 5'd7, 0, 32'd15);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, 2, 5, 5'd1, 0, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2, 0, 3, 5'd2, 0, 32'hFFFF_FFFF);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 1, 1, 5'd3, 0, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, 2, 5'd5, 1, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 0, 4, 5'd6, 0, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd0, 5'd8, 0, 2, 5'd8, 0, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd7, 32'd0, 5'd10, 0, 2, 5'd10, 0, 32'd7);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 2, 5'd11, 0, 32'h8000_0000);
        run_op(3'd0, 32'd6, 32'd7, 5'd4, 0, 3, 5'd4, 5, 32'd42);
        run_op(3'd0, 32'd2, 32'd2, 5'd9, 0, 2, 5'd3, 0, 32'd4);
        run_op(3'd0, 32'd1, 32'd1, 5'd0, 0, 1, 5'd0, 0, 32'd1);

        flush_in_wait(10, 1'b0);
        flush_in_wait(3, 1'b1);

        issue_to_wait(3'd5, 32'd9, 32'd3, 5'd14, 0);
        repeat (TIMEOUT - 1) step();
        exp_kill = 1'b1;
        exp_to   = 1'b1;
        @(negedge clock);
        chk("timeout_pulse", {md_kill, timeout_err}, 2'b11);
        @(posedge clock);
        #1;
        exp_kill = 1'b0;
        exp_to   = 1'b0;
        ph = 0;
        step();

        // Response in the final allowed cycle must still complete normally.
        run_op(3'd0, 32'd4, 32'd4, 5'd15, 0, TIMEOUT, 5'd15, 0, 32'd16);

        issue_to_wait(3'd0, 32'd8, 32'd8, 5'd16, 0);
        respond(2, 5'd16);
        flush = 1'b1;
        step();
        flush = 1'b0;
        ph = 0;
        step();

        inst_valid = 1'b1; inst_funct3 = 3'd0; inst_rs1 = 32'd1; inst_rs2 = 32'd1; inst_rd = 5'd17;
        exp_f3 = 3'd0; exp_in1 = 32'd1; exp_in2 = 32'd1; exp_rd = 5'd17;
        step();
        inst_valid = 1'b0;
        ph = 1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        ph = 0;

        inst_valid = 1'b1;
        flush = 1'b1;
        step();
        inst_valid = 1'b0;
        flush = 1'b0;
        step();

        issue_to_wait(3'd0, 32'd5, 32'd5, 5'd18, 0);
        repeat (3) step();
        reset = 1'b1;
        step();
        ph = 0;
        exp_done = '0;
        step();
        reset = 1'b0;
        step();

        run_op(3'd0, 32'd9, 32'd9, 5'd19, 0, 2, 5'd19, 0, 32'd81);
        @(negedge clock);
        chk("done_after_reset", done_count, 32'd1);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
